fg_fd_queue: RTL

FG_FD_QUEUE -- requirements
Module: fg_fd_queue

---
 rtl/fg_fd_queue_pkg.sv | 16 +
 rtl/fg_sdp_ram.sv | 35 +++
 rtl/fg_fd_queue.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fg_fd_queue_pkg.sv
// Shared flow-generator constants: descriptor field widths and packed descriptor size.
package fg_fd_queue_pkg;

    localparam int unsigned RATE_WIDTH     = 16;
    localparam int unsigned LEN_WIDTH_DEF  = 32;
    localparam int unsigned DEST_WIDTH_DEF = 8;
    localparam int unsigned DROP_CNT_WIDTH = 16;

    // Packed order (MSB first): dest, rate_num, rate_denom, len, burst_len.
    function automatic int unsigned fd_width(input int unsigned dest_w, input int unsigned len_w);
        return dest_w + 2 * RATE_WIDTH + 2 * len_w;
    endfunction

    localparam int unsigned FD_WIDTH_DEF = fd_width(DEST_WIDTH_DEF, LEN_WIDTH_DEF);

endpackage

// File: rtl/fg_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port whose output resets to zero.
module fg_sdp_ram #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/fg_fd_queue.sv
// Flow descriptor FIFO: RAM plus output register, with occupancy/byte accounting,
// optional drop-on-full and synchronous flush.
module fg_fd_queue
    import fg_fd_queue_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DEST_WIDTH     = DEST_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH      = LEN_WIDTH_DEF,
    parameter bit          DROP_WHEN_FULL = 1'b0,
    parameter int unsigned AFULL_THRESH   = 2 ** ADDR_WIDTH - 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                input_fd_valid,
    output logic                                input_fd_ready,
    input  logic [DEST_WIDTH-1:0]               input_fd_dest,
    input  logic [RATE_WIDTH-1:0]               input_fd_rate_num,
    input  logic [RATE_WIDTH-1:0]               input_fd_rate_denom,
    input  logic [LEN_WIDTH-1:0]                input_fd_len,
    input  logic [LEN_WIDTH-1:0]                input_fd_burst_len,
    output logic                                output_fd_valid,
    input  logic                                output_fd_ready,
    output logic [DEST_WIDTH-1:0]               output_fd_dest,
    output logic [RATE_WIDTH-1:0]               output_fd_rate_num,
    output logic [RATE_WIDTH-1:0]               output_fd_rate_denom,
    output logic [LEN_WIDTH-1:0]                output_fd_len,
    output logic [LEN_WIDTH-1:0]                output_fd_burst_len,
    input  logic                                flush,
    output logic [ADDR_WIDTH:0]                 count,
    output logic [ADDR_WIDTH+LEN_WIDTH:0]       byte_count,
    output logic                                almost_full,
    output logic [DROP_CNT_WIDTH-1:0]           drop_count
);

    localparam int unsigned PTR_W  = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned BYTE_W = ADDR_WIDTH + LEN_WIDTH + 1;
    localparam int unsigned FD_W   = fd_width(DEST_WIDTH, LEN_WIDTH);

    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic                      out_valid_q, out_valid_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [BYTE_W-1:0]         byte_count_q, byte_count_d;
    logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;

    logic            empty, full, wr_en, rd_en, pop, drop;
    logic [FD_W-1:0] wr_data, rd_data;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    assign input_fd_ready = DROP_WHEN_FULL ? ~flush : (~full & ~flush);
    assign wr_en = input_fd_valid & ~flush & ~full;
    assign drop  = DROP_WHEN_FULL & input_fd_valid & ~flush & full;
    assign pop   = out_valid_q & output_fd_ready;
    assign rd_en = ~flush & ~empty & (output_fd_ready | ~out_valid_q);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_valid_d  = out_valid_q;
        count_d      = count_q;
        byte_count_d = byte_count_q;
        drop_count_d = drop_count_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            out_valid_d  = 1'b0;
            count_d      = '0;
            byte_count_d = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            out_valid_d  = rd_en | (out_valid_q & ~output_fd_ready);
            count_d      = count_q + CNT_W'(wr_en) - CNT_W'(pop);
            byte_count_d = byte_count_q
                         + (wr_en ? BYTE_W'(input_fd_len)  : BYTE_W'(0))
                         - (pop   ? BYTE_W'(output_fd_len) : BYTE_W'(0));
            if (drop && (drop_count_q != '1)) begin
                drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            count_q      <= '0;
            byte_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_valid_q  <= out_valid_d;
            count_q      <= count_d;
            byte_count_q <= byte_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign wr_data = {input_fd_dest, input_fd_rate_num, input_fd_rate_denom,
                      input_fd_len, input_fd_burst_len};

    // The RAM read register doubles as the output register.
    fg_sdp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (FD_W)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (rd_data)
    );

    assign {output_fd_dest, output_fd_rate_num, output_fd_rate_denom,
            output_fd_len, output_fd_burst_len} = rd_data;

    assign output_fd_valid = out_valid_q;
    assign count           = count_q;
    assign byte_count      = byte_count_q;
    assign drop_count      = drop_count_q;
    assign almost_full     = (count_q >= CNT_W'(AFULL_THRESH));

endmodule
